// File: rtl/r2sdf_stage_if.sv
// Streaming complex-sample bus into and out of one R2SDF butterfly stage.
interface r2sdf_stage_if #(
    parameter int WIDTH = 13,
    parameter int TW_AW = 4
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [TW_AW-1:0]        tw_idx;

    modport master (
        output in_valid, in_re, in_im,
        input  out_valid, out_re, out_im, tw_idx
    );

    modport slave (
        input  in_valid, in_re, in_im,
        output out_valid, out_re, out_im, tw_idx
    );
endinterface

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: pairs samples DELAY apart,
// emits sums in the second half of a block and the stored differences in the next block's first half.
module r2sdf_stage #(
    parameter int WIDTH     = 13,
    parameter int DELAY     = 8,
    parameter int SCALE     = 1,
    parameter int TW_AW     = 4,
    parameter int TW_STRIDE = 1
) (
    input logic           clk,
    input logic           rst,
    r2sdf_stage_if.slave  bus
);
    localparam int CW = $clog2(2 * DELAY);
    localparam int JW = $clog2(DELAY);
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    primed_q, primed_d;
    logic signed [WIDTH-1:0] line_re_q [DELAY];
    logic signed [WIDTH-1:0] line_re_d [DELAY];
    logic signed [WIDTH-1:0] line_im_q [DELAY];
    logic signed [WIDTH-1:0] line_im_d [DELAY];
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_re_q, out_re_d;
    logic signed [WIDTH-1:0] out_im_q, out_im_d;
    logic [TW_AW-1:0]        tw_q, tw_d;

    logic signed [WIDTH-1:0] d_re, d_im;
    logic signed [WIDTH:0]   s_re_w, s_im_w, t_re_w, t_im_w;
    logic                    phase_b;
    logic [JW-1:0]           j;

    // Bring a WIDTH+1 bit sum/difference back to WIDTH bits: halve (floor) or saturate.
    function automatic logic signed [WIDTH-1:0] fit(input logic signed [WIDTH:0] v);
        if (SCALE != 0)
            return v[WIDTH:1];
        else if (v[WIDTH] != v[WIDTH-1])
            return v[WIDTH] ? MINV : MAXV;
        else
            return v[WIDTH-1:0];
    endfunction

    assign d_re    = line_re_q[DELAY-1];
    assign d_im    = line_im_q[DELAY-1];
    assign phase_b = cnt_q[CW-1];
    assign j       = cnt_q[JW-1:0];

    assign s_re_w = {d_re[WIDTH-1], d_re} + {bus.in_re[WIDTH-1], bus.in_re};
    assign s_im_w = {d_im[WIDTH-1], d_im} + {bus.in_im[WIDTH-1], bus.in_im};
    assign t_re_w = {d_re[WIDTH-1], d_re} - {bus.in_re[WIDTH-1], bus.in_re};
    assign t_im_w = {d_im[WIDTH-1], d_im} - {bus.in_im[WIDTH-1], bus.in_im};

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        line_re_d   = line_re_q;
        line_im_d   = line_im_q;
        out_valid_d = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        tw_d        = tw_q;
        if (bus.in_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == '1)
                primed_d = 1'b1;
            for (int i = 1; i < DELAY; i++) begin
                line_re_d[i] = line_re_q[i-1];
                line_im_d[i] = line_im_q[i-1];
            end
            if (!phase_b) begin
                // Head of the line holds the previous block's difference for index j.
                line_re_d[0] = bus.in_re;
                line_im_d[0] = bus.in_im;
                out_valid_d  = primed_q;
                out_re_d     = d_re;
                out_im_d     = d_im;
                tw_d         = TW_AW'(j) * TW_AW'(TW_STRIDE);
            end else begin
                line_re_d[0] = fit(t_re_w);
                line_im_d[0] = fit(t_im_w);
                out_valid_d  = 1'b1;
                out_re_d     = fit(s_re_w);
                out_im_d     = fit(s_im_w);
                tw_d         = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            tw_q        <= '0;
            for (int i = 0; i < DELAY; i++) begin
                line_re_q[i] <= '0;
                line_im_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            tw_q        <= tw_d;
            line_re_q   <= line_re_d;
            line_im_q   <= line_im_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.tw_idx    = tw_q;
endmodule

// File: tb/tb_r2sdf_stage.sv
// Four stage configurations share one random/directed stream and are checked each cycle against a block-level FFT-butterfly model.
module tb_r2sdf_stage;
    localparam int NU = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              cur_v  = 1'b0;
    logic signed [12:0] cur_re = '0;
    logic signed [12:0] cur_im = '0;

    int checks = 0;
    int errors = 0;

    r2sdf_stage_if #(.WIDTH(13), .TW_AW(2)) b0 ();
    r2sdf_stage_if #(.WIDTH(13), .TW_AW(2)) b1 ();
    r2sdf_stage_if #(.WIDTH(13), .TW_AW(4)) b2 ();
    r2sdf_stage_if #(.WIDTH(13), .TW_AW(3)) b3 ();

    assign b0.in_valid = cur_v; assign b0.in_re = cur_re; assign b0.in_im = cur_im;
    assign b1.in_valid = cur_v; assign b1.in_re = cur_re; assign b1.in_im = cur_im;
    assign b2.in_valid = cur_v; assign b2.in_re = cur_re; assign b2.in_im = cur_im;
    assign b3.in_valid = cur_v; assign b3.in_re = cur_re; assign b3.in_im = cur_im;

    r2sdf_stage #(.WIDTH(13), .DELAY(2), .SCALE(0), .TW_AW(2), .TW_STRIDE(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    r2sdf_stage #(.WIDTH(13), .DELAY(2), .SCALE(1), .TW_AW(2), .TW_STRIDE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    r2sdf_stage #(.WIDTH(13), .DELAY(8), .SCALE(1), .TW_AW(4), .TW_STRIDE(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
    r2sdf_stage #(.WIDTH(13), .DELAY(4), .SCALE(0), .TW_AW(3), .TW_STRIDE(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    int P_D  [NU] = '{2, 2, 8, 4};
    int P_S  [NU] = '{0, 1, 1, 0};
    int P_TW [NU] = '{2, 2, 4, 3};
    int P_ST [NU] = '{1, 1, 1, 3};

    // Model: collect each block of 2*D samples; sums of x[j],x[j+D] appear as x[j+D] arrives,
    // differences appear during the following block's first half.
    int blk_re [NU][16];
    int blk_im [NU][16];
    int pt_re  [NU][8];
    int pt_im  [NU][8];
    int ct_re  [NU][8];
    int ct_im  [NU][8];
    int m_k    [NU];
    bit m_pr   [NU];
    bit e_v    [NU];
    int e_re   [NU];
    int e_im   [NU];
    int e_tw   [NU];

    int mq0_re[$], mq0_tw[$], mq1_re[$], mq1_tw[$];
    int dq0_re[$], dq0_tw[$], dq1_re[$], dq1_tw[$];

    function automatic int wrule(int v, int sc);
        if (sc != 0) return v >>> 1;
        if (v > 4095) return 4095;
        if (v < -4096) return -4096;
        return v;
    endfunction

    task automatic m_reset(int u);
        m_k[u] = 0; m_pr[u] = 1'b0; e_v[u] = 1'b0;
        e_re[u] = 0; e_im[u] = 0; e_tw[u] = 0;
    endtask

    task automatic m_accept(int u, int xr, int xi);
        int k = m_k[u];
        int d = P_D[u];
        blk_re[u][k] = xr;
        blk_im[u][k] = xi;
        if (k < d) begin
            e_v[u]  = m_pr[u];
            e_re[u] = m_pr[u] ? pt_re[u][k] : 0;
            e_im[u] = m_pr[u] ? pt_im[u][k] : 0;
            e_tw[u] = (k * P_ST[u]) % (1 << P_TW[u]);
        end else begin
            int jj = k - d;
            e_v[u]  = 1'b1;
            e_re[u] = wrule(blk_re[u][jj] + xr, P_S[u]);
            e_im[u] = wrule(blk_im[u][jj] + xi, P_S[u]);
            ct_re[u][jj] = wrule(blk_re[u][jj] - xr, P_S[u]);
            ct_im[u][jj] = wrule(blk_im[u][jj] - xi, P_S[u]);
            e_tw[u] = 0;
        end
        if (k == 2 * d - 1) begin
            for (int i = 0; i < d; i++) begin
                pt_re[u][i] = ct_re[u][i];
                pt_im[u][i] = ct_im[u][i];
            end
            m_pr[u] = 1'b1;
            m_k[u]  = 0;
        end else begin
            m_k[u] = k + 1;
        end
        if (e_v[u] && u == 0) begin mq0_re.push_back(e_re[u]); mq0_tw.push_back(e_tw[u]); end
        if (e_v[u] && u == 1) begin mq1_re.push_back(e_re[u]); mq1_tw.push_back(e_tw[u]); end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < NU; u++) m_reset(u);
        end else begin
            for (int u = 0; u < NU; u++) begin
                if (cur_v) m_accept(u, int'(cur_re), int'(cur_im));
                else e_v[u] = 1'b0;
            end
        end
    end

    task automatic chk(int u, string nm, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL u%0d %s @%0t got %0d exp %0d", u, nm, $time, got, exp);
        end
    endtask

    task automatic cmp(int u, logic v, logic signed [12:0] re, logic signed [12:0] im, int tw);
        chk(u, "out_valid", int'(v), int'(e_v[u]));
        chk(u, "out_re", int'(re), e_re[u]);
        chk(u, "out_im", int'(im), e_im[u]);
        chk(u, "tw_idx", tw, e_tw[u]);
    endtask

    always @(negedge clk) begin
        #1;
        cmp(0, b0.out_valid, b0.out_re, b0.out_im, int'(b0.tw_idx));
        cmp(1, b1.out_valid, b1.out_re, b1.out_im, int'(b1.tw_idx));
        cmp(2, b2.out_valid, b2.out_re, b2.out_im, int'(b2.tw_idx));
        cmp(3, b3.out_valid, b3.out_re, b3.out_im, int'(b3.tw_idx));
        if (b0.out_valid) begin dq0_re.push_back(int'(b0.out_re)); dq0_tw.push_back(int'(b0.tw_idx)); end
        if (b1.out_valid) begin dq1_re.push_back(int'(b1.out_re)); dq1_tw.push_back(int'(b1.tw_idx)); end
    end

    task automatic check_seq(string nm, input int qr[$], input int qt[$], input int er[4], input int et[4]);
        chk(0, {nm, "_count"}, (qr.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < qr.size()) begin
                chk(0, $sformatf("%s_re[%0d]", nm, i), qr[i], er[i]);
                chk(0, $sformatf("%s_tw[%0d]", nm, i), qt[i], et[i]);
            end
        end
    endtask

    task automatic clear_q();
        mq0_re.delete(); mq0_tw.delete(); mq1_re.delete(); mq1_tw.delete();
        dq0_re.delete(); dq0_tw.delete(); dq1_re.delete(); dq1_tw.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cur_v = 1'b0;
        @(negedge clk);
        #2;
        chk(0, "rst_out_valid", int'(b0.out_valid), 0);
        chk(0, "rst_out_re", int'(b0.out_re), 0);
        chk(2, "rst_tw_idx", int'(b2.tw_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_q();
    endtask

    task automatic send(int re, int im);
        @(negedge clk);
        cur_v = 1'b1; cur_re = re[12:0]; cur_im = im[12:0];
    endtask

    task automatic gap();
        @(negedge clk);
        cur_v = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) gap();
    endtask

    task automatic feed_t1(bit gapped);
        int pat [9] = '{1, 0, 0, 1, 0, 1, 1, 0, 1};
        int xs  [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
        int idx = 0;
        int p = 0;
        while (idx < 8) begin
            if (!gapped || pat[p % 9] != 0) begin
                send(xs[idx], 0);
                idx++;
            end else begin
                gap();
            end
            p++;
        end
        idle(3);
    endtask

    function automatic int rv();
        case ($urandom_range(0, 7))
            0: return -4096;
            1: return 4095;
            default: return int'($urandom_range(0, 8191)) - 4096;
        endcase
    endfunction

    initial begin
        do_reset();
        feed_t1(1'b0);
        check_seq("t1_dut", dq0_re, dq0_tw, '{4, 6, -2, -2}, '{0, 0, 0, 1});
        check_seq("t1_model", mq0_re, mq0_tw, '{4, 6, -2, -2}, '{0, 0, 0, 1});

        do_reset();
        send(4000, 0); send(-4096, 0); send(4000, 0); send(4000, 0);
        send(0, 0); send(0, 0); idle(3);
        check_seq("t2_dut", dq0_re, dq0_tw, '{4095, -96, 0, -4096}, '{0, 0, 0, 1});
        check_seq("t2_model", mq0_re, mq0_tw, '{4095, -96, 0, -4096}, '{0, 0, 0, 1});

        do_reset();
        send(4000, 0); send(-3, 0); send(4000, 0); send(0, 0);
        send(0, 0); send(0, 0); idle(3);
        check_seq("t3_dut", dq1_re, dq1_tw, '{4000, -2, 0, -2}, '{0, 0, 0, 1});
        check_seq("t3_model", mq1_re, mq1_tw, '{4000, -2, 0, -2}, '{0, 0, 0, 1});

        do_reset();
        feed_t1(1'b1);
        check_seq("t4_dut", dq0_re, dq0_tw, '{4, 6, -2, -2}, '{0, 0, 0, 1});

        do_reset();
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        send(9, 5); send(8, -5); send(7, 3);
        do_reset();
        feed_t1(1'b0);
        check_seq("t5_dut", dq0_re, dq0_tw, '{4, 6, -2, -2}, '{0, 0, 0, 1});

        do_reset();
        begin
            int sent = 0;
            while (sent < 8 * 16 + 16) begin
                if ($urandom_range(0, 3) != 0) begin
                    send(rv(), rv());
                    sent++;
                end else begin
                    gap();
                end
            end
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
